// File: rtl/adc_multi_scaler.sv
// adc_multi_scaler: per-channel block averager feeding a multiply/shift
// scaler with saturation and a show-ahead output FIFO.
`timescale 1ns/1ps

// Single-channel block averager: sums 2^AVG_POWER samples, then reports the
// mean combinationally on the sample that completes the block.
module adc_ch_avg #(
    parameter int DATA_W    = 16,
    parameter int AVG_POWER = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              hit,
    input  logic [DATA_W-1:0] data,
    output logic              done,
    output logic [DATA_W-1:0] avg
);
    localparam int ACC_W = DATA_W + AVG_POWER;

    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     sum;
    logic [AVG_POWER-1:0] cnt;

    assign sum  = acc + ACC_W'(data);
    assign done = hit & (&cnt);
    assign avg  = sum[ACC_W-1:AVG_POWER];

    // Accumulate accepted samples; restart the block on the completing one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (hit) begin
            if (&cnt) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module adc_multi_scaler #(
    parameter int          NUM_CH         = 4,
    parameter int          DATA_W         = 16,
    parameter int          AVG_POWER      = 8,
    parameter int unsigned SCALING_FACTOR = 79993,
    parameter int          SHIFT_FACTOR   = 19,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          CH_W           = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [CH_W-1:0]   sample_ch,
    input  logic [DATA_W-1:0] sample_data,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [CH_W-1:0]   result_ch,
    output logic [DATA_W-1:0] result_avg,
    output logic [DATA_W-1:0] result_scaled,
    output logic              result_sat,
    output logic              overflow_err,
    output logic              bad_ch_err,
    input  logic              clear_err
);
    localparam int PROD_W = DATA_W + $clog2(SCALING_FACTOR) + 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int STAGES = 2;
    localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);
    localparam logic [PROD_W-1:0] SCALE_L = PROD_W'(SCALING_FACTOR);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] avg;
        logic [DATA_W-1:0] scaled;
        logic              sat;
    } res_t;

    // ---------------- sample intake ----------------
    logic in_range, accept, bad_evt;
    assign in_range = ({1'b0, sample_ch} < NUM_CH_L);
    assign accept   = sample_valid & en & ~clear & in_range;
    assign bad_evt  = sample_valid & ~in_range;

    logic [NUM_CH-1:0]             ch_hit;
    logic [NUM_CH-1:0]             ch_done;
    logic [NUM_CH-1:0][DATA_W-1:0] ch_avg;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_hit[c] = accept & (sample_ch == CH_W'(c));
        adc_ch_avg #(.DATA_W(DATA_W), .AVG_POWER(AVG_POWER)) u_avg (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (clear),
            .hit     (ch_hit[c]),
            .data    (sample_data),
            .done    (ch_done[c]),
            .avg     (ch_avg[c])
        );
    end

    // At most one channel completes per cycle, so a priority pick is exact
    logic              cmp_done;
    logic [CH_W-1:0]   cmp_ch;
    logic [DATA_W-1:0] cmp_avg;
    always_comb begin
        cmp_done = |ch_done;
        cmp_ch   = '0;
        cmp_avg  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_done[c]) begin
                cmp_ch  = CH_W'(c);
                cmp_avg = ch_avg[c];
            end
        end
    end

    // ---------------- scaler pipeline ----------------
    logic [STAGES:0]   vld_pipe;
    logic [CH_W-1:0]   s1_ch, s2_ch;
    logic [DATA_W-1:0] s1_avg, s2_avg;
    logic [PROD_W-1:0] s2_prod, s2_shift;
    res_t              s3;

    assign s2_shift = s2_prod >> SHIFT_FACTOR;

    // Average -> full-width product -> shifted and saturated result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            s1_ch    <= '0;
            s1_avg   <= '0;
            s2_ch    <= '0;
            s2_avg   <= '0;
            s2_prod  <= '0;
            s3       <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], cmp_done};
            if (cmp_done) begin
                s1_ch  <= cmp_ch;
                s1_avg <= cmp_avg;
            end
            if (vld_pipe[0]) begin
                s2_ch   <= s1_ch;
                s2_avg  <= s1_avg;
                s2_prod <= PROD_W'(s1_avg) * SCALE_L;
            end
            if (vld_pipe[1]) begin
                s3.ch  <= s2_ch;
                s3.avg <= s2_avg;
                s3.sat <= |s2_shift[PROD_W-1:DATA_W];
                s3.scaled <= (|s2_shift[PROD_W-1:DATA_W]) ? {DATA_W{1'b1}}
                                                          : s2_shift[DATA_W-1:0];
            end
        end
    end

    // ---------------- output FIFO ----------------
    res_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    res_t          head, hold_q, show;
    logic          full, do_pop, do_push, ovf_evt;

    assign full         = (count == (AW+1)'(FIFO_DEPTH));
    assign result_valid = (count != '0);
    assign do_pop       = result_valid & result_ready;
    assign do_push      = vld_pipe[STAGES] & (~full | do_pop);
    assign ovf_evt      = vld_pipe[STAGES] & full & ~do_pop;
    assign head         = mem[rd_ptr];
    assign show         = result_valid ? head : hold_q;

    assign result_ch     = show.ch;
    assign result_avg    = show.avg;
    assign result_scaled = show.scaled;
    assign result_sat    = show.sat;

    // Ring buffer; hold_q keeps the last head visible once the FIFO drains
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= s3;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
            if (result_valid) hold_q <= head;
        end
    end

    // Sticky error flags; a new event beats a same-cycle clear_err
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_err <= 1'b0;
            bad_ch_err   <= 1'b0;
        end else begin
            if (ovf_evt)        overflow_err <= 1'b1;
            else if (clear_err) overflow_err <= 1'b0;
            if (bad_evt)        bad_ch_err <= 1'b1;
            else if (clear_err) bad_ch_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adc_multi_scaler.sv
// Randomized and directed bench for adc_multi_scaler against a queue-based
// reference model of the averaging, scaling and FIFO rules.
`timescale 1ns/1ps

module tb_adc_multi_scaler;
    localparam int     NUM_CH = 4;
    localparam int     DATA_W = 16;
    localparam int     AVG_POWER = 2;
    localparam longint SCALING_FACTOR = 79993;
    localparam int     SHIFT_FACTOR = 15;
    localparam int     FIFO_DEPTH = 4;
    localparam int     CH_W = 4;
    localparam int     BLK = 1 << AVG_POWER;

    logic clk = 0, reset_n = 0;
    logic en = 0, clear = 0, sample_valid = 0, result_ready = 0, clear_err = 0;
    logic [CH_W-1:0]   sample_ch = '0;
    logic [DATA_W-1:0] sample_data = '0;
    logic              result_valid, result_sat, overflow_err, bad_ch_err;
    logic [CH_W-1:0]   result_ch;
    logic [DATA_W-1:0] result_avg, result_scaled;

    adc_multi_scaler #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_POWER(AVG_POWER),
        .SCALING_FACTOR(SCALING_FACTOR), .SHIFT_FACTOR(SHIFT_FACTOR),
        .FIFO_DEPTH(FIFO_DEPTH), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_ch(result_ch), .result_avg(result_avg), .result_scaled(result_scaled),
        .result_sat(result_sat), .overflow_err(overflow_err), .bad_ch_err(bad_ch_err),
        .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] avg;
        logic [DATA_W-1:0] scaled;
        logic              sat;
    } res_t;

    res_t   m_fifo[$];
    res_t   m_pipe[$];
    int     m_due[$];
    int     m_cyc;
    longint m_sum[NUM_CH];
    int     m_cnt[NUM_CH];
    bit     m_ovf, m_bad;
    res_t   m_last;

    function automatic res_t mk(input int ch, input longint sum);
        res_t r;
        longint avg, sc;
        avg = sum / BLK;
        sc  = (avg * SCALING_FACTOR) / (longint'(1) << SHIFT_FACTOR);
        r.ch  = CH_W'(ch);
        r.avg = DATA_W'(avg);
        if (sc > 65535) begin r.scaled = 16'hFFFF; r.sat = 1'b1; end
        else begin r.scaled = DATA_W'(sc); r.sat = 1'b0; end
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_fifo.delete(); m_pipe.delete(); m_due.delete();
            m_cyc = 0; m_ovf = 0; m_bad = 0; m_last = '0;
            for (int c = 0; c < NUM_CH; c++) begin m_sum[c] = 0; m_cnt[c] = 0; end
        end else begin
            bit popping, ovf_now;
            res_t r;
            m_cyc++;
            popping = (m_fifo.size() > 0) && result_ready;
            ovf_now = 0;
            if (popping) void'(m_fifo.pop_front());
            if (m_due.size() > 0 && m_due[0] == m_cyc) begin
                void'(m_due.pop_front());
                r = m_pipe.pop_front();
                if (m_fifo.size() >= FIFO_DEPTH) ovf_now = 1;
                else m_fifo.push_back(r);
            end
            if (ovf_now) m_ovf = 1; else if (clear_err) m_ovf = 0;
            if (sample_valid && sample_ch >= NUM_CH) m_bad = 1;
            else if (clear_err) m_bad = 0;
            if (clear) begin
                for (int c = 0; c < NUM_CH; c++) begin m_sum[c] = 0; m_cnt[c] = 0; end
            end else if (sample_valid && en && sample_ch < NUM_CH) begin
                m_sum[sample_ch] += sample_data;
                m_cnt[sample_ch]++;
                if (m_cnt[sample_ch] == BLK) begin
                    m_pipe.push_back(mk(int'(sample_ch), m_sum[sample_ch]));
                    m_due.push_back(m_cyc + 3);
                    m_sum[sample_ch] = 0;
                    m_cnt[sample_ch] = 0;
                end
            end
        end
    end

    // Every cycle out of reset, the DUT outputs must match the model
    always @(negedge clk) begin
        if (reset_n) begin
            if (m_fifo.size() > 0) m_last = m_fifo[0];
            chk("m_valid", result_valid, m_fifo.size() > 0);
            chk("m_ch", result_ch, m_last.ch);
            chk("m_avg", result_avg, m_last.avg);
            chk("m_scaled", result_scaled, m_last.scaled);
            chk("m_sat", result_sat, m_last.sat);
            chk("m_ovf", overflow_err, m_ovf);
            chk("m_bad", bad_ch_err, m_bad);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic send(input int ch, input int data);
        sample_valid = 1; sample_ch = CH_W'(ch); sample_data = DATA_W'(data);
        step();
        sample_valid = 0;
    endtask

    task automatic expect_pop(input int ch, input int avg, input int sc, input int sat);
        int k = 0;
        @(negedge clk);
        while (!result_valid && k < 30) begin @(negedge clk); k++; end
        chk("pop_wait", result_valid, 1);
        chk("pop_ch", result_ch, ch);
        chk("pop_avg", result_avg, avg);
        if (sc >= 0) begin
            chk("pop_scaled", result_scaled, sc);
            chk("pop_sat", result_sat, sat);
        end
        result_ready = 1;
        step();
        result_ready = 0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, result_valid, 0);
        chk({nm, "_ch"}, result_ch, 0);
        chk({nm, "_avg"}, result_avg, 0);
        chk({nm, "_scaled"}, result_scaled, 0);
        chk({nm, "_sat"}, result_sat, 0);
        chk({nm, "_ovf"}, overflow_err, 0);
        chk({nm, "_bad"}, bad_ch_err, 0);
    endtask

    initial begin
        // reset state
        #13; chk_zero("rst");
        repeat (2) step();
        reset_n = 1;
        en = 1;
        step();

        // basic average with latency: result visible 4 edges after last sample
        send(1, 100); send(1, 200); send(1, 300); send(1, 400);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("lat_lo", result_valid, 0);
            step();
        end
        @(negedge clk); chk("lat_hi", result_valid, 1);
        expect_pop(1, 250, 610, 0);

        // interleaved channels, saturated and zero results in completion order
        for (int i = 0; i < BLK; i++) begin send(0, 16'hFFFF); send(2, 0); end
        expect_pop(0, 16'hFFFF, 16'hFFFF, 1);
        expect_pop(2, 0, 0, 0);

        // overflow: five results into a four-deep FIFO with no consumer
        for (int b = 1; b <= 5; b++)
            for (int i = 0; i < BLK; i++) send(3, 10 * b);
        repeat (6) step();
        @(negedge clk); chk("ovf_set", overflow_err, 1);
        for (int b = 1; b <= 4; b++) expect_pop(3, 10 * b, -1, 0);
        repeat (2) step();
        @(negedge clk); chk("ovf_drained", result_valid, 0);
        clear_err = 1; step(); clear_err = 0;
        @(negedge clk); chk("ovf_cleared", overflow_err, 0);

        // bad channel, clear mid-block, en low ignores samples
        send(NUM_CH, 77);
        @(negedge clk); chk("bad_set", bad_ch_err, 1);
        send(1, 1000); send(1, 1000); send(1, 1000);
        clear = 1; send(1, 5000); clear = 0;
        en = 0; send(1, 60000); send(1, 60000); en = 1;
        for (int i = 0; i < BLK; i++) send(1, 8);
        expect_pop(1, 8, 19, 0);
        clear_err = 1; step(); clear_err = 0;

        // async reset with two entries held and a third between E1 and E2
        for (int i = 0; i < BLK; i++) send(2, 500);
        for (int i = 0; i < BLK; i++) send(2, 600);
        repeat (5) step();
        for (int i = 0; i < BLK; i++) send(0, 4000);
        @(posedge clk); #3;
        reset_n = 0;
        #1; chk_zero("amid");
        step();
        reset_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); chk("post_rst_empty", result_valid, 0);
            step();
        end
        for (int i = 0; i < BLK; i++) send(3, 1234);
        expect_pop(3, 1234, 3012, 0);

        // randomized traffic checked by the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sample_valid = ($urandom % 4) != 0;
            sample_ch    = CH_W'(($urandom % 16 == 0) ? (NUM_CH + $urandom % 3) : $urandom % NUM_CH);
            sample_data  = DATA_W'($urandom);
            en           = ($urandom % 8) != 0;
            clear        = ($urandom % 64) == 0;
            result_ready = ($urandom % 3) == 0;
            clear_err    = ($urandom % 32) == 0;
            if (cyc == 1500) begin
                @(posedge clk); #4; reset_n = 0; #3; chk_zero("rnd_rst");
                step(); reset_n = 1;
            end else begin
                step();
            end
        end
        sample_valid = 0; clear = 0; clear_err = 0; result_ready = 1;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
